stream_decode_stage: RTL and testbench



---
 rtl/stream_codec_pkg.sv | 20 ++
 rtl/stream_fifo.sv | 58 +++++
 rtl/stream_decode_stage.sv | 52 +++++
 tb/tb_stream_decode_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_codec_pkg.sv
// Shared byte-stream codec definitions used by both the encode and decode stages.
package stream_codec_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t CODEC_KEY = 8'hA5;

    // Encoder side: rotate left by one, then XOR with the key.
    function automatic byte_t codec_encode(input byte_t b, input byte_t key);
        return {b[6:0], b[7]} ^ key;
    endfunction

    // Exact inverse of codec_encode: XOR with the key, then rotate right by one.
    function automatic byte_t codec_decode(input byte_t b, input byte_t key);
        byte_t d;
        d = b ^ key;
        return {d[0], d[7:1]};
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Byte-wide elastic FIFO with valid/ready on both sides; all outputs come from registered state.
module stream_fifo
    import stream_codec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  byte_t                    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output byte_t                    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    byte_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Ready is based on the registered level only, so a pop in the full
    // cycle frees a slot for the following cycle, never the same one.
    assign in_ready  = (level < FULL_LEVEL);
    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // NOTE: storage is cleared on reset as well, so the head reads 8'h00
    // after reset instead of X; every state bit here uses non-blocking <=.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/stream_decode_stage.sv
// Receive-side decode stage: decodes incoming bytes, buffers them, and counts deliveries.
module stream_decode_stage
    import stream_codec_pkg::*;
#(
    parameter byte_t KEY   = CODEC_KEY,
    parameter int    DEPTH = 4,
    parameter int    CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               enc_data_in,
    input  logic                     enc_valid_in,
    output logic                     enc_ready_out,
    output logic [7:0]               dec_data_out,
    output logic                     dec_valid_out,
    input  logic                     dec_ready_in,
    output logic [$clog2(DEPTH):0]   level_out,
    output logic [CNT_W-1:0]         byte_count_out,
    input  logic                     clear_count
);

    byte_t decoded;

    // Decode at write time so the FIFO already holds plain bytes.
    assign decoded = codec_decode(enc_data_in, KEY);

    stream_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (decoded),
        .in_valid  (enc_valid_in),
        .in_ready  (enc_ready_out),
        .out_data  (dec_data_out),
        .out_valid (dec_valid_out),
        .out_ready (dec_ready_in),
        .level     (level_out)
    );

    // Saturating delivery counter; clear wins over a same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_count_out <= '0;
        end else if (clear_count) begin
            byte_count_out <= '0;
        end else if (dec_valid_out && dec_ready_in && (byte_count_out != '1)) begin
            byte_count_out <= byte_count_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_decode_stage.sv
// Scoreboard bench for stream_decode_stage; a second instance with a 4-bit counter covers saturation.
module tb_stream_decode_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  enc_data_in;
    logic        enc_valid_in;
    logic        dec_ready_in;
    logic        clear_count;

    logic        enc_ready_out;
    logic [7:0]  dec_data_out;
    logic        dec_valid_out;
    logic [2:0]  level_out;
    logic [15:0] byte_count_out;

    logic        enc_ready_c4;
    logic [7:0]  dec_data_c4;
    logic        dec_valid_c4;
    logic [2:0]  level_c4;
    logic [3:0]  byte_count_c4;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] cnt16_m;
    logic [3:0]  cnt4_m;
    logic        hold_v;
    logic [7:0]  hold_d;

    always #5 clk = ~clk;

    stream_decode_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enc_data_in    (enc_data_in),
        .enc_valid_in   (enc_valid_in),
        .enc_ready_out  (enc_ready_out),
        .dec_data_out   (dec_data_out),
        .dec_valid_out  (dec_valid_out),
        .dec_ready_in   (dec_ready_in),
        .level_out      (level_out),
        .byte_count_out (byte_count_out),
        .clear_count    (clear_count)
    );

    stream_decode_stage #(.CNT_W(4)) dut_c4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .enc_data_in    (enc_data_in),
        .enc_valid_in   (enc_valid_in),
        .enc_ready_out  (enc_ready_c4),
        .dec_data_out   (dec_data_c4),
        .dec_valid_out  (dec_valid_c4),
        .dec_ready_in   (dec_ready_in),
        .level_out      (level_c4),
        .byte_count_out (byte_count_c4),
        .clear_count    (clear_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_encode(input logic [7:0] b);
        return {b[6:0], b[7]} ^ 8'hA5;
    endfunction

    function automatic logic [7:0] model_decode(input logic [7:0] x);
        logic [7:0] d;
        d = x ^ 8'hA5;
        return {d[0], d[7:1]};
    endfunction

    // Monitor: inputs change just after posedge, so the negedge sees this cycle's handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cnt16_m = '0;
            cnt4_m  = '0;
            hold_v  = 1'b0;
        end else begin
            check("level", 32'(level_out), 32'(exp_q.size()));
            check("enc_ready", 32'(enc_ready_out), 32'(exp_q.size() < DEPTH));
            check("dec_valid", 32'(dec_valid_out), 32'(exp_q.size() != 0));
            check("count16", 32'(byte_count_out), 32'(cnt16_m));
            check("count4", 32'(byte_count_c4), 32'(cnt4_m));
            if (hold_v) begin
                check("hold_valid", 32'(dec_valid_out), 32'd1);
                check("hold_data", 32'(dec_data_out), 32'(hold_d));
            end
            if (dec_valid_out && dec_ready_in) begin
                if (exp_q.size() == 0) check("pop_q_size", 32'(exp_q.size()), 32'd1);
                else check("pop_data", 32'(dec_data_out), 32'(exp_q.pop_front()));
                if (cnt16_m != '1) cnt16_m = cnt16_m + 1'b1;
                if (cnt4_m != '1) cnt4_m = cnt4_m + 1'b1;
            end
            if (clear_count) begin
                cnt16_m = '0;
                cnt4_m  = '0;
            end
            if (enc_valid_in && enc_ready_out) exp_q.push_back(model_decode(enc_data_in));
            hold_v = dec_valid_out && !dec_ready_in;
            hold_d = dec_data_out;
        end
    end

    // Presents one byte and returns #1 after the edge on which it was accepted.
    task automatic push_byte(input logic [7:0] x);
        enc_data_in  = x;
        enc_valid_in = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (enc_ready_out) begin
                @(posedge clk); #1;
                enc_valid_in = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("push_timeout", 32'(enc_ready_out), 32'd1);
        enc_valid_in = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        enc_data_in  = '0;
        enc_valid_in = 1'b0;
        dec_ready_in = 1'b0;
        clear_count  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", 32'(level_out), 32'd0);
        check("rst_valid", 32'(dec_valid_out), 32'd0);
        check("rst_ready", 32'(enc_ready_out), 32'd1);
        check("rst_data", 32'(dec_data_out), 32'h00);
        check("rst_count", 32'(byte_count_out), 32'd0);
        rst_n = 1'b1;

        // First byte: one-cycle latency, then popped.
        dec_ready_in = 1'b1;
        push_byte(8'hDD);
        check("first_valid", 32'(dec_valid_out), 32'd1);
        check("first_data", 32'(dec_data_out), 32'h3C);
        @(posedge clk); #1;
        check("first_count", 32'(byte_count_out), 32'd1);
        check("first_level", 32'(level_out), 32'd0);

        push_byte(8'hA6);
        check("a6_data", 32'(dec_data_out), 32'h81);
        for (int b = 0; b < 256; b++) push_byte(model_encode(8'(b)));
        wait_empty();

        // Fill to DEPTH with the sink stalled; fifth byte waits upstream.
        dec_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
        check("full_level", 32'(level_out), 32'd4);
        check("full_ready", 32'(enc_ready_out), 32'd0);
        enc_data_in  = 8'h55;
        enc_valid_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        dec_ready_in = 1'b1;
        @(negedge clk);
        check("pop_full_ready", 32'(enc_ready_out), 32'd0);
        @(posedge clk); #1;
        check("ready_after_pop", 32'(enc_ready_out), 32'd1);
        @(posedge clk); #1;
        enc_valid_in = 1'b0;
        wait_empty();

        // Streaming: one byte per cycle at steady level 1, pointers wrap several times.
        for (int i = 0; i < 20; i++) begin
            push_byte(8'($urandom_range(0, 255)));
            check("stream_level", 32'(level_out), 32'd1);
        end
        wait_empty();

        // 283 pops so far: the 4-bit counter sits at all-ones.
        check("c4_saturated", 32'(byte_count_c4), 32'hF);
        check("c16_total", 32'(byte_count_out), 32'd283);
        clear_count = 1'b1;
        push_byte(8'h42);
        @(posedge clk); #1;
        clear_count = 1'b0;
        check("clear_c16", 32'(byte_count_out), 32'd0);
        check("clear_c4", 32'(byte_count_c4), 32'd0);

        // Asynchronous reset with three bytes buffered.
        dec_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
        check("pre_rst_level", 32'(level_out), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(dec_valid_out), 32'd0);
        check("mid_rst_level", 32'(level_out), 32'd0);
        check("mid_rst_ready", 32'(enc_ready_out), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dec_ready_in = 1'b1;
        push_byte(8'hDD);
        check("post_rst_data", 32'(dec_data_out), 32'h3C);
        wait_empty();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
